// File: rtl/cmd_bus_arbiter_if.sv
// Handshake bundle between the command arbiter, its requesters and cmd_proc.
// The arbiter takes the slave side; requesters and cmd_proc drive the master side.
interface cmd_bus_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0][15:0] cmd_in;
  logic [NUM_REQ-1:0]       cmd_rdy_in;
  logic [NUM_REQ-1:0]       lock_req;
  logic [NUM_REQ-1:0]       clr_cmd_rdy_out;
  logic [NUM_REQ-1:0]       done;
  logic [15:0]              cmd;
  logic                     cmd_rdy;
  logic                     clr_cmd_rdy;
  logic                     send_resp;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic                     timeout;

  modport slave (
    input  cmd_in, cmd_rdy_in, lock_req, clr_cmd_rdy, send_resp,
    output clr_cmd_rdy_out, done, cmd, cmd_rdy, grant, busy, timeout
  );

  modport master (
    output cmd_in, cmd_rdy_in, lock_req, clr_cmd_rdy, send_resp,
    input  clr_cmd_rdy_out, done, cmd, cmd_rdy, grant, busy, timeout
  );
endinterface

// File: rtl/cmd_bus_arbiter.sv
// Round-robin arbiter sharing the single cmd_proc command port among requesters,
// with per-owner bus lock and a watchdog that frees the bus from a stalled command.
module cmd_bus_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = 1 << 26
) (
  input logic             clk,
  input logic             rst,
  cmd_bus_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, LOCKED} state_t;

  state_t             state;
  logic [1:0]         last;
  logic [CW-1:0]      wd_cnt;
  logic [15:0]        cmd_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               cmd_rdy_q;
  logic               busy_q;
  logic               timeout_q;
  logic               wd_expire;
  logic               ack_fire;
  logic               resp_fire;
  logic [1:0]         win;

  // Nearest set request after 'l' in circular order; scanning far-to-near lets the nearest overwrite.
  function automatic logic [1:0] rr_pick(input logic [1:0] l, input logic [NUM_REQ-1:0] r);
    logic [1:0] w;
    int         c;
    w = l;
    for (int k = NUM_REQ; k >= 1; k--) begin
      c = (int'(l) + k) % NUM_REQ;
      if (r[c]) w = 2'(c);
    end
    return w;
  endfunction

  assign win       = rr_pick(last, bus.cmd_rdy_in);
  assign wd_expire = (state != IDLE) && (wd_cnt == CW'(TIMEOUT_CYC - 1));
  // Handshakes are swallowed on the expiry cycle so a timeout never looks like a completion.
  assign ack_fire  = (state == ISSUE) && bus.clr_cmd_rdy && !wd_expire;
  assign resp_fire = (state == BUSY) && bus.send_resp && !wd_expire;

  assign bus.cmd     = cmd_q;
  assign bus.cmd_rdy = cmd_rdy_q;
  assign bus.grant   = grant_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign bus.clr_cmd_rdy_out[i] = ack_fire & grant_q[i];
    assign bus.done[i]            = resp_fire & grant_q[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 2'd2;
      wd_cnt    <= '0;
      cmd_q     <= '0;
      grant_q   <= '0;
      cmd_rdy_q <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (wd_expire) begin
        // last is kept so the stalled owner drops to lowest priority.
        state     <= IDLE;
        wd_cnt    <= '0;
        grant_q   <= '0;
        cmd_rdy_q <= 1'b0;
        busy_q    <= 1'b0;
        timeout_q <= 1'b1;
      end else begin
        wd_cnt <= (state == IDLE) ? '0 : wd_cnt + 1'b1;
        case (state)
          IDLE: begin
            if (|bus.cmd_rdy_in) begin
              grant_q   <= NUM_REQ'(1) << win;
              cmd_q     <= bus.cmd_in[win];
              last      <= win;
              cmd_rdy_q <= 1'b1;
              busy_q    <= 1'b1;
              state     <= ISSUE;
            end
          end
          ISSUE: begin
            if (bus.clr_cmd_rdy) begin
              cmd_rdy_q <= 1'b0;
              wd_cnt    <= '0;
              state     <= BUSY;
            end
          end
          BUSY: begin
            if (bus.send_resp) begin
              wd_cnt <= '0;
              if (|(bus.lock_req & grant_q)) begin
                state <= LOCKED;
              end else begin
                grant_q <= '0;
                busy_q  <= 1'b0;
                state   <= IDLE;
              end
            end
          end
          LOCKED: begin
            // last always names the owner here; a pending command outranks lock release.
            if (bus.cmd_rdy_in[last]) begin
              cmd_q     <= bus.cmd_in[last];
              cmd_rdy_q <= 1'b1;
              wd_cnt    <= '0;
              state     <= ISSUE;
            end else if (!bus.lock_req[last]) begin
              grant_q <= '0;
              busy_q  <= 1'b0;
              wd_cnt  <= '0;
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/cmd_bus_arbiter.md
Name: cmd_bus_arbiter

Overview:
- Shares the single cmd_proc command port among three requesters: UART wrapper (req 0), tour replay sequencer (req 1) and a calibration/self-test sequencer (req 2).
- Round-robin arbitrates between requests, captures and presents the winning command, and routes the clr_cmd_rdy and send_resp handshakes back to the granted requester only.
- Supports a lock, so a requester can hold the bus across a multi-command sequence such as an L-move, and a watchdog that recovers the bus from a stalled command.

Parameters:
- NUM_REQ, 3, number of requesters; fixed at 3 for this design.
- TIMEOUT_CYC, 2^26, cycles allowed in any non-IDLE state before forced release (about 1.3 s at 50 MHz).

Ports:
- clk  input  1  50 MHz system clock.
- rst  input  1  synchronous, active-high reset.
- cmd_in  input  48  requester commands; bits [16i+15:16i] belong to requester i.
- cmd_rdy_in  input  3  per-requester command-valid; held high until that requester's clr_cmd_rdy_out bit pulses.
- lock_req  input  3  per-requester bus-lock request.
- clr_cmd_rdy_out  output  3  one-cycle acknowledge to the granted requester.
- done  output  3  one-cycle command-complete to the granted requester.
- cmd  output  16  command to cmd_proc.
- cmd_rdy  output  1  command-valid to cmd_proc.
- clr_cmd_rdy  input  1  cmd_proc has accepted the command.
- send_resp  input  1  cmd_proc has finished the command.
- grant  output  3  one-hot current owner; 0 when free.
- busy  output  1  high in any state other than IDLE.
- timeout  output  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge; applies mid-operation too):
  - state goes to IDLE.
  - cmd_q=0, cmd_rdy=0, grant=0, clr_cmd_rdy_out=0, done=0, busy=0, timeout=0.
  - Round-robin pointer last=2, so req 0 wins the first arbitration.
  - Watchdog counter is cleared.
- States: IDLE, ISSUE, BUSY, LOCKED.
- IDLE:
  - If any cmd_rdy_in bit is high, the winner is the first set bit searching last+1, last+2, last+3 (mod 3).
  - Registered: grant<=onehot(winner), cmd_q<=cmd_in slice of winner, last<=winner, go to ISSUE.
  - Latency from cmd_rdy_in to cmd_rdy at cmd_proc is 1 cycle.
- ISSUE:
  - cmd_rdy=1 and cmd=cmd_q.
  - On clr_cmd_rdy: clr_cmd_rdy_out[grant]=1 combinationally in the same cycle, next state BUSY.
  - send_resp is ignored in ISSUE, including when it coincides with clr_cmd_rdy.
- BUSY:
  - cmd_rdy=0; cmd holds cmd_q.
  - On send_resp: done[grant]=1 combinationally.
  - Then, if lock_req[grant]=1, go to LOCKED with grant held; otherwise grant<=0 and go to IDLE.
- LOCKED:
  - Only the owner is served; other requests wait.
  - If cmd_rdy_in[owner]=1: cmd_q<=owner slice, go to ISSUE. This is checked before the lock-release condition.
  - Otherwise, if lock_req[owner]=0: grant<=0, go to IDLE.
- cmd output holds cmd_q in all states; cmd_q only changes on a capture.
- cmd_rdy_in or cmd_in changing after capture does not affect the command in flight.
- lock_req is sampled only on the BUSY→next transition and in LOCKED. Raising it while IDLE has no effect until the requester is granted.
- Watchdog:
  - Counter clears on every state change and counts while in ISSUE, BUSY or LOCKED.
  - On reaching TIMEOUT_CYC-1: timeout=1 for one cycle, cmd_rdy=0, grant<=0, lock dropped, state IDLE.
  - No clr_cmd_rdy_out or done pulse is issued on timeout.
  - last is left unchanged, so the stalled requester becomes lowest priority.
- A requester that lost arbitration keeps cmd_rdy_in high and is served in a later IDLE arbitration; no request is dropped.
- clr_cmd_rdy and send_resp arriving in IDLE or LOCKED are ignored.
- Widths: counter is clog2(TIMEOUT_CYC) bits; pointer 2 bits, value 3 never used.

Test Plan:
- Single grant, handshake routing: reset; cmd_rdy_in=3'b001, cmd_in[15:0]=16'h4002 → next cycle grant=001, cmd_rdy=1, cmd=16'h4002. Pulse clr_cmd_rdy → clr_cmd_rdy_out=001 in the same cycle. Pulse send_resp → done=001, then grant=000 and busy=0.
- Round robin: cmd_rdy_in=3'b111 held, each command completed → grants in order 001, 010, 100, 001. Each cmd matches its slice (16'h1111, 16'h2222, 16'h3333).
- Lock across an L-move: req1 holds lock_req=1 and issues 16'h4002 then 16'h5BF1 while req0 keeps cmd_rdy_in=1 → grant stays 010 for both commands. After lock_req drops, LOCKED→IDLE, then grant=001.
- Simultaneous events: in ISSUE, assert clr_cmd_rdy and send_resp in the same cycle → only clr_cmd_rdy_out pulses, done does not. A later send_resp in BUSY produces done.
- Watchdog: TIMEOUT_CYC=16; grant req2, pulse clr_cmd_rdy, withhold send_resp → timeout pulses exactly 16 cycles after BUSY entry, grant=000, done=000, state IDLE.
- Reset mid-operation: assert rst for one cycle while in BUSY with grant=010 → the following cycle cmd=0, cmd_rdy=0, grant=000, busy=0. The next arbitration with cmd_rdy_in=111 grants 001.
